// File: rtl/fan_ctrl_pkg.sv
// Shared types, default thresholds and the state-to-duty lookup for the fan controller.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
// Optional feature macro used by this block: FAN_SPINUP_EN (spin-up kick).
package fan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_CRIT = 2'd3
    } fan_state_e;

    localparam int DEF_TEMP_W     = 12;
    localparam int DEF_PWM_W      = 4;
    localparam int DEF_SAMPLE_DIV = 10;
    localparam int DEF_T_ON       = 28;
    localparam int DEF_T_OFF      = 26;
    localparam int DEF_T_HIGH     = 32;
    localparam int DEF_T_HIGH_OFF = 30;
    localparam int DEF_T_CRIT     = 40;
    localparam int DEF_DUTY_LOW   = 6;
    localparam int DEF_DUTY_HIGH  = 12;
    localparam int DEF_MIN_ON     = 8;
    localparam int DEF_SPINUP_CYC = 16;

    // Duty count the PWM should apply while sitting in a given state.
    function automatic int unsigned state_duty(
        input fan_state_e  st,
        input int unsigned duty_low,
        input int unsigned duty_high,
        input int unsigned duty_full
    );
        int unsigned d;
        d = 0;
        case (st)
            ST_LOW:  d = duty_low;
            ST_HIGH: d = duty_high;
            ST_CRIT: d = duty_full;
            default: d = 0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/fan_pwm_gen.sv
// PWM generator: free-running counter, wrap-synchronous duty load, force and optional spin-up kick.
// Latency: fan_pwm is registered, one cycle after the count/force it reflects; duty changes apply next period.
// Backpressure: none; free-running. Spin-up counter exists only with FAN_SPINUP_EN defined.
module fan_pwm_gen
    import fan_ctrl_pkg::*;
#(
    parameter int PWM_W = DEF_PWM_W
`ifdef FAN_SPINUP_EN
    , parameter int SPINUP_CYC = DEF_SPINUP_CYC
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst,
`ifdef FAN_SPINUP_EN
    input  logic             i_kick,
    input  logic             i_cancel,
`endif
    input  logic [PWM_W-1:0] i_target,
    input  logic             i_force,
    output logic [PWM_W-1:0] o_duty,
    output logic             o_pwm
);

    localparam logic [PWM_W-1:0] CNT_MAX = '1;

    logic [PWM_W-1:0] r_cnt;
    logic [PWM_W-1:0] r_duty;
    logic             r_pwm;
    logic             w_spin_force;

    // Free-running period counter; duty only changes on the last count so a period is never split.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_duty <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_MAX) begin
                r_duty <= i_target;
            end
        end
    end

`ifdef FAN_SPINUP_EN
    localparam int SPIN_W = $clog2(SPINUP_CYC + 1);

    logic [SPIN_W-1:0] r_spin;

    // Spin-up countdown: the kick cycle itself drives high, then SPINUP_CYC-1 more cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_cancel) begin
            r_spin <= '0;
        end else if (i_kick) begin
            r_spin <= SPIN_W'(SPINUP_CYC - 1);
        end else if (r_spin != '0) begin
            r_spin <= r_spin - 1'b1;
        end
    end

    assign w_spin_force = (i_kick || (r_spin != '0)) && !i_cancel;
`else
    assign w_spin_force = 1'b0;
`endif

    // Registered output keeps the fan drive glitch-free.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= (r_cnt < r_duty) || i_force || w_spin_force;
        end
    end

    assign o_duty = r_duty;
    assign o_pwm  = r_pwm;

endmodule

// File: rtl/fan_ctrl_sched.sv
// Fan supervisor: periodic sensor read request, hysteresis speed FSM, alarm latch and PWM drive.
// Latency: state registers 1 cycle after a valid sample; duty follows at the next PWM wrap; CRIT drives PWM at once.
// Backpressure: none; every temp_valid is consumed. Optional spin-up kick under FAN_SPINUP_EN.
module fan_ctrl_sched
    import fan_ctrl_pkg::*;
#(
    parameter int TEMP_W     = DEF_TEMP_W,
    parameter int PWM_W      = DEF_PWM_W,
    parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
    parameter int T_ON       = DEF_T_ON,
    parameter int T_OFF      = DEF_T_OFF,
    parameter int T_HIGH     = DEF_T_HIGH,
    parameter int T_HIGH_OFF = DEF_T_HIGH_OFF,
    parameter int T_CRIT     = DEF_T_CRIT,
    parameter int DUTY_LOW   = DEF_DUTY_LOW,
    parameter int DUTY_HIGH  = DEF_DUTY_HIGH,
`ifdef FAN_SPINUP_EN
    parameter int MIN_ON     = DEF_MIN_ON,
    parameter int SPINUP_CYC = DEF_SPINUP_CYC
`else
    parameter int MIN_ON     = DEF_MIN_ON
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_temp_valid,
    input  logic [TEMP_W-1:0] i_temp,
    input  logic              i_alarm_clr,
    output logic              o_sample_req,
    output logic              o_fan_on,
    output logic              o_fan_pwm,
    output logic [PWM_W-1:0]  o_duty,
    output logic [1:0]        o_state,
    output logic              o_alarm,
    output logic              o_alarm_latched
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int ON_W  = $clog2(MIN_ON + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [ON_W-1:0]   ON_SAT     = ON_W'(MIN_ON);
    localparam logic [TEMP_W-1:0] L_T_ON     = TEMP_W'(T_ON);
    localparam logic [TEMP_W-1:0] L_T_OFF    = TEMP_W'(T_OFF);
    localparam logic [TEMP_W-1:0] L_T_HIGH   = TEMP_W'(T_HIGH);
    localparam logic [TEMP_W-1:0] L_T_HI_OFF = TEMP_W'(T_HIGH_OFF);
    localparam logic [TEMP_W-1:0] L_T_CRIT   = TEMP_W'(T_CRIT);

    fan_state_e       r_state;
    fan_state_e       w_state_nxt;
    logic [DIV_W-1:0] r_div_cnt;
    logic [ON_W-1:0]  r_on_cnt;
    logic             r_alarm_latched;
    logic [PWM_W-1:0] w_target;
    logic             w_force;

    // Sample-request divider: wraps every SAMPLE_DIV cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign o_sample_req = (r_div_cnt == DIV_LAST);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: only a valid sample can move the FSM; CRIT check outranks per-state hysteresis.
    always_comb begin
        w_state_nxt = r_state;
        if (i_temp_valid) begin
            if (i_temp >= L_T_CRIT) begin
                w_state_nxt = ST_CRIT;
            end else begin
                case (r_state)
                    ST_OFF: begin
                        if (i_temp > L_T_ON) begin
                            w_state_nxt = (i_temp >= L_T_HIGH) ? ST_HIGH : ST_LOW;
                        end
                    end
                    ST_LOW: begin
                        if (i_temp >= L_T_HIGH) begin
                            w_state_nxt = ST_HIGH;
                        end else if ((i_temp < L_T_OFF) && (r_on_cnt >= ON_SAT)) begin
                            w_state_nxt = ST_OFF;
                        end
                    end
                    ST_HIGH: begin
                        if (i_temp < L_T_HI_OFF) begin
                            w_state_nxt = ST_LOW;
                        end
                    end
                    ST_CRIT: begin
                        if (i_temp < L_T_HIGH) begin
                            w_state_nxt = ST_HIGH;
                        end
                    end
                    default: w_state_nxt = ST_OFF;
                endcase
            end
        end
    end

    // Minimum-on counter: restarts when leaving OFF, counts valid samples while running, saturates.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_on_cnt <= '0;
        end else if ((r_state == ST_OFF) || (w_state_nxt == ST_OFF)) begin
            r_on_cnt <= '0;
        end else if (i_temp_valid && (r_on_cnt < ON_SAT)) begin
            r_on_cnt <= r_on_cnt + 1'b1;
        end
    end

    // Sticky alarm: set on CRIT entry, clear request only honoured outside CRIT; set beats clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_alarm_latched <= 1'b0;
        end else if ((w_state_nxt == ST_CRIT) && (r_state != ST_CRIT)) begin
            r_alarm_latched <= 1'b1;
        end else if (i_alarm_clr && (r_state != ST_CRIT)) begin
            r_alarm_latched <= 1'b0;
        end
    end

    // Forcing from the next state lets PWM go high on the same edge the FSM enters CRIT.
    assign w_force  = (w_state_nxt == ST_CRIT);
    assign w_target = PWM_W'(state_duty(r_state, int'(DUTY_LOW), int'(DUTY_HIGH),
                                        int'((1 << PWM_W) - 1)));

`ifdef FAN_SPINUP_EN
    logic w_kick;
    logic w_cancel;

    assign w_kick   = (r_state == ST_OFF) &&
                      ((w_state_nxt == ST_LOW) || (w_state_nxt == ST_HIGH));
    assign w_cancel = (r_state != ST_OFF) && (w_state_nxt == ST_OFF);

    fan_pwm_gen #(
        .PWM_W      (PWM_W),
        .SPINUP_CYC (SPINUP_CYC)
    ) u_pwm (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_kick   (w_kick),
        .i_cancel (w_cancel),
        .i_target (w_target),
        .i_force  (w_force),
        .o_duty   (o_duty),
        .o_pwm    (o_fan_pwm)
    );
`else
    fan_pwm_gen #(
        .PWM_W (PWM_W)
    ) u_pwm (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_target (w_target),
        .i_force  (w_force),
        .o_duty   (o_duty),
        .o_pwm    (o_fan_pwm)
    );
`endif

    assign o_state         = r_state;
    assign o_fan_on        = (r_state != ST_OFF);
    assign o_alarm         = (r_state == ST_CRIT);
    assign o_alarm_latched = r_alarm_latched;

endmodule

// File: tb/tb_fan_ctrl_sched.sv
// Self-checking bench for fan_ctrl_sched: vector table with scoreboard plus hand-written PWM/reset sequences.
module tb_fan_ctrl_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        temp_valid;
    logic [11:0] temp;
    logic        alarm_clr;
    logic        sample_req;
    logic        fan_on;
    logic        fan_pwm;
    logic [3:0]  duty;
    logic [1:0]  state;
    logic        alarm;
    logic        alarm_latched;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [11:0] temp;
        logic        clr;
        logic [1:0]  st;
        logic        latched;
    } vec_t;

    typedef struct {
        logic [1:0] st;
        logic       on;
        logic       al;
        logic       lat;
    } exp_t;

    vec_t vecs[30];
    exp_t sb[$];

    always #5 clk = ~clk;

    fan_ctrl_sched dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_temp_valid    (temp_valid),
        .i_temp          (temp),
        .i_alarm_clr     (alarm_clr),
        .o_sample_req    (sample_req),
        .o_fan_on        (fan_on),
        .o_fan_pwm       (fan_pwm),
        .o_duty          (duty),
        .o_state         (state),
        .o_alarm         (alarm),
        .o_alarm_latched (alarm_latched)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic v, input int t, input logic c,
                           input logic [1:0] s, input logic l);
        vecs[i] = '{v, 12'(t), c, s, l};
    endtask

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            exp_t e;
            @(negedge clk);
            temp_valid = vecs[i].valid;
            temp       = vecs[i].temp;
            alarm_clr  = vecs[i].clr;
            e.st  = vecs[i].st;
            e.on  = (vecs[i].st != 2'd0);
            e.al  = (vecs[i].st == 2'd3);
            e.lat = vecs[i].latched;
            sb.push_back(e);
            @(posedge clk);
            #1;
            temp_valid = 1'b0;
            alarm_clr  = 1'b0;
            e = sb.pop_front();
            check($sformatf("vec%0d state", i), int'(state), int'(e.st));
            check($sformatf("vec%0d fan_on", i), int'(fan_on), int'(e.on));
            check($sformatf("vec%0d alarm", i), int'(alarm), int'(e.al));
            check($sformatf("vec%0d alarm_latched", i), int'(alarm_latched), int'(e.lat));
        end
    endtask

    task automatic wait_duty(input string name, input int exp);
        int found;
        found = 0;
        for (int k = 0; k < 18 && found == 0; k++) begin
            @(posedge clk);
            #1;
            if (int'(duty) == exp) found = 1;
        end
        check(name, int'(duty), exp);
    endtask

    task automatic count_pwm(input string name, input int exp);
        int n;
        n = 0;
        repeat (16) begin
            @(posedge clk);
            #1;
            n += int'(fan_pwm);
        end
        check(name, n, exp);
    endtask

    task automatic settle_spin();
`ifdef FAN_SPINUP_EN
        repeat (16) @(posedge clk);
        #1;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b1;
        temp_valid = 1'b0;
        alarm_clr  = 1'b0;
        @(posedge clk);
        #1;
        check("reset outputs", int'({fan_on, fan_pwm, duty, state, alarm, alarm_latched}), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        temp_valid = 1'b0;
        temp       = '0;
        alarm_clr  = 1'b0;

        // idx: valid temp clr -> state latched
        set_vec(0,  1, 27, 0, 2'd0, 0);
        set_vec(1,  1, 28, 0, 2'd0, 0);
        set_vec(2,  1, 29, 0, 2'd1, 0);
        for (int i = 3; i <= 10; i++) set_vec(i, 1, 25, 0, 2'd1, 0);
        set_vec(11, 1, 25, 0, 2'd0, 0);
        set_vec(12, 1, 33, 0, 2'd2, 0);
        set_vec(13, 1, 31, 0, 2'd2, 0);
        set_vec(14, 1, 30, 0, 2'd2, 0);
        set_vec(15, 1, 29, 0, 2'd1, 0);
        set_vec(16, 1, 32, 0, 2'd2, 0);
        set_vec(17, 1, 20, 0, 2'd1, 0);
        set_vec(18, 1, 26, 0, 2'd1, 0);
        set_vec(19, 1, 20, 0, 2'd1, 0);
        set_vec(20, 1, 20, 0, 2'd1, 0);
        set_vec(21, 1, 26, 0, 2'd1, 0);
        set_vec(22, 1, 41, 0, 2'd3, 1);
        set_vec(23, 0, 0,  1, 2'd3, 1);
        set_vec(24, 1, 35, 0, 2'd3, 1);
        set_vec(25, 1, 31, 0, 2'd2, 1);
        set_vec(26, 0, 0,  1, 2'd2, 0);
        set_vec(27, 1, 40, 1, 2'd3, 1);
        set_vec(28, 1, 31, 0, 2'd2, 1);
        set_vec(29, 0, 0,  1, 2'd2, 0);

        repeat (3) @(posedge clk);
        do_reset();

        // Scheduler after reset release, with all other outputs idle.
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("sample_req k=%0d", k), int'(sample_req), (k % 10 == 9) ? 1 : 0);
            check($sformatf("idle outs k=%0d", k),
                  int'({fan_on, fan_pwm, duty, state, alarm, alarm_latched}), 0);
        end

        // OFF -> LOW and its duty.
        run_vectors(0, 2);
        settle_spin();
        wait_duty("duty LOW", 6);
        count_pwm("pwm LOW", 6);

        // Minimum-on hold, then OFF.
        run_vectors(3, 11);
        wait_duty("duty OFF", 0);
        count_pwm("pwm OFF", 0);

        // OFF -> HIGH.
        run_vectors(12, 12);
        settle_spin();
        wait_duty("duty HIGH", 12);
        count_pwm("pwm HIGH", 12);

        // Hysteresis boundaries.
        run_vectors(13, 21);

        // CRIT entry drives PWM on the same edge.
        run_vectors(22, 22);
        check("crit pwm immediate", int'(fan_pwm), 1);
        wait_duty("duty CRIT", 15);
        count_pwm("pwm CRIT", 16);

        // Alarm clear behaviour.
        run_vectors(23, 29);

        // Reset while PWM is being forced high.
        @(negedge clk);
        temp_valid = 1'b1;
        temp       = 12'd45;
        @(posedge clk);
        #1;
        temp_valid = 1'b0;
        check("crit again pwm", int'(fan_pwm), 1);
        repeat (3) @(posedge clk);
        do_reset();

`ifdef FAN_SPINUP_EN
        // Spin-up kick length, then normal duty.
        @(negedge clk);
        temp_valid = 1'b1;
        temp       = 12'd29;
        @(posedge clk);
        #1;
        temp_valid = 1'b0;
        check("spin state", int'(state), 1);
        check("spin k=0", int'(fan_pwm), 1);
        for (int k = 1; k < 16; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("spin k=%0d", k), int'(fan_pwm), 1);
        end
        count_pwm("pwm after spin", 6);

        // Reset in the middle of a kick.
        do_reset();
        @(negedge clk);
        temp_valid = 1'b1;
        temp       = 12'd29;
        @(posedge clk);
        #1;
        temp_valid = 1'b0;
        for (int k = 1; k < 5; k++) begin
            @(posedge clk);
            #1;
        end
        check("spin before rst", int'(fan_pwm), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("spin rst pwm", int'(fan_pwm), 0);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fan_ctrl_sched.md
Name: fan_ctrl_sched

Overview:
- Supervisory controller for the temperature-sensor / fan datapath.
- Schedules sensor reads with a periodic request strobe and consumes each valid temperature sample.
- Sequences the fan through speed states using hysteresis thresholds and a minimum-on interval.
- Drives a glitch-free PWM fan output plus a level fan_on and an over-temperature alarm; sits between the temperature sensor and the fan driver.

Parameters:
- TEMP_W, 12, temperature sample width (unsigned)
- PWM_W, 4, PWM counter width; period = 2**PWM_W cycles
- SAMPLE_DIV, 10, cycles between sample_req pulses (>=2)
- T_ON, 28, OFF->on threshold (strictly greater)
- T_OFF, 26, on->OFF threshold (strictly less)
- T_HIGH, 32, LOW->HIGH threshold (>=)
- T_HIGH_OFF, 30, HIGH->LOW threshold (strictly less)
- T_CRIT, 40, any->CRIT threshold (>=)
- DUTY_LOW, 6, LOW-state duty count
- DUTY_HIGH, 12, HIGH-state duty count
- MIN_ON, 8, valid samples required before returning to OFF
- SPINUP_CYC, 16, spin-up kick length in cycles (optional feature)

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- temp_valid  in  1  sample strobe from sensor
- temp  in  TEMP_W  temperature sample, qualified by temp_valid
- alarm_clr  in  1  clears sticky alarm_latched
- sample_req  out  1  one-cycle read request to sensor
- fan_on  out  1  high in any state except OFF
- fan_pwm  out  1  PWM drive to fan
- duty  out  PWM_W  currently applied duty count
- state  out  2  OFF=0, LOW=1, HIGH=2, CRIT=3
- alarm  out  1  high while in CRIT
- alarm_latched  out  1  sticky CRIT indicator

Behaviour:
- Reset (rst=1 at posedge): state=OFF, all outputs 0, all counters 0. Reset mid-PWM-period or mid-spin-up aborts immediately; no residual pulse.
- Scheduler: div_cnt counts 0..SAMPLE_DIV-1 and wraps.
  - sample_req=1 for exactly the cycle div_cnt==SAMPLE_DIV-1; first pulse SAMPLE_DIV cycles after reset release.
  - temp_valid is accepted any cycle, independent of sample_req; no ready/backpressure.
- FSM: evaluated only on cycles with temp_valid=1; the new state is registered at that edge (1-cycle latency). Priority top-down:
  - any state: temp>=T_CRIT -> CRIT
  - OFF: temp>T_ON -> HIGH if temp>=T_HIGH, else LOW
  - LOW: temp>=T_HIGH -> HIGH; else temp<T_OFF and on_cnt>=MIN_ON -> OFF
  - HIGH: temp<T_HIGH_OFF -> LOW (never directly to OFF)
  - CRIT: temp<T_HIGH -> HIGH
  - otherwise hold
- Comparisons are unsigned at TEMP_W. Thresholds are zero-extended.
- on_cnt:
  - cleared on any transition into LOW/HIGH from OFF, and held at 0 in OFF;
  - increments on each temp_valid while not OFF, saturating at MIN_ON;
  - a sample below T_OFF before saturation keeps LOW.
- fan_on and alarm are combinational decodes of registered state.
- alarm_latched sets on entry to CRIT and clears on alarm_clr only when not in CRIT. If set and clear coincide, set wins.
- PWM:
  - pwm_cnt is free-running 0..2**PWM_W-1 with wrap.
  - Target duty per state: OFF 0, LOW DUTY_LOW, HIGH DUTY_HIGH, CRIT full.
  - duty register loads the target only on the cycle pwm_cnt==max, so the change applies from the next period.
  - fan_pwm is registered: (pwm_cnt<duty), or 1 when state==CRIT.
  - Exception: entry to CRIT forces fan_pwm=1 next cycle without waiting for the wrap.
  - Entry to OFF does not force fan_pwm low; it follows the duty update at the next wrap.

Optional Feature:
- Macro FAN_SPINUP_EN.
- Defined: on an OFF->LOW or OFF->HIGH transition, fan_pwm is forced 1 for SPINUP_CYC cycles starting the cycle after the transition. Normal PWM resumes after that.
  - A transition back to OFF, or rst, cancels the kick.
  - CRIT entry during the kick keeps fan_pwm=1.
- Undefined: no spin-up counter exists; PWM follows duty immediately.

Decomposition:
- Package fan_ctrl_pkg holds:
  - fan_state_e enum (OFF/LOW/HIGH/CRIT, 2-bit)
  - state-to-duty lookup function
  - default threshold constants
- Sub-module fan_pwm_gen holds pwm_cnt, the wrap-synchronous duty load, the force input and, under FAN_SPINUP_EN, the spin-up counter.

Test Plan:
- Reset release with SAMPLE_DIV=10 -> sample_req pulses at cycles 10, 20, 30; all outputs 0 until the first valid sample.
- Samples 27, 29 -> stays OFF on 27; LOW after 29, fan_on=1; duty becomes 6 at the next pwm_cnt wrap; fan_pwm high 6 of 16 cycles.
- LOW, then 5 samples of 25 followed by 3 more -> stays LOW until on_cnt reaches 8, then OFF; duty becomes 0 after the wrap.
- Samples 33, 31, 29 -> HIGH (duty 12), stays HIGH at 31, LOW at 29; no direct HIGH->OFF on 20.
- Sample 41 mid-period -> CRIT next cycle, fan_pwm=1 immediately, alarm=1 and alarm_latched=1. alarm_clr while in CRIT is ignored; after sample 31 -> HIGH, and alarm_clr then clears alarm_latched.
- FAN_SPINUP_EN defined, OFF then sample 29 -> fan_pwm=1 for 16 cycles, then 6/16 duty; rst asserted at spin-up cycle 5 -> fan_pwm=0 the next cycle.
